// File: rtl/set_pkg.sv
// set_pkg: shared state, field and target codes for the setting-mode controller
package set_pkg;
    typedef enum logic [1:0] {RUN, SET_T, XFER, SET_A} state_t;
    typedef enum logic [1:0] {F_NONE = 2'd0, F_H = 2'd1, F_M = 2'd2, F_S = 2'd3} field_t;
    typedef enum logic {T_TIME = 1'b0, T_ALARM = 1'b1} target_t;

    // Strobe order: {H_UP, H_DOWN, M_UP, M_DOWN, S_UP, S_DOWN}
    function automatic logic [5:0] step_decode(field_t f, logic up, logic dn);
        return {f == F_H && up, f == F_H && dn, f == F_M && up, f == F_M && dn,
                f == F_S && up, f == F_S && dn};
    endfunction
endpackage

// File: rtl/set_ctrl_if.sv
// set_ctrl_if: debounced key inputs and adjust-counter control outputs of set_ctrl
interface set_ctrl_if;
    logic       TICK, K_MODE, K_SEL, K_INC, K_DEC;
    logic       SETTING, TARGET, LOAD, COMMIT;
    logic [1:0] FIELD;
    logic       H_UP, H_DOWN, M_UP, M_DOWN, S_UP, S_DOWN;

    modport master(
        output TICK, K_MODE, K_SEL, K_INC, K_DEC,
        input  SETTING, TARGET, LOAD, COMMIT, FIELD,
        input  H_UP, H_DOWN, M_UP, M_DOWN, S_UP, S_DOWN
    );
    modport slave(
        input  TICK, K_MODE, K_SEL, K_INC, K_DEC,
        output SETTING, TARGET, LOAD, COMMIT, FIELD,
        output H_UP, H_DOWN, M_UP, M_DOWN, S_UP, S_DOWN
    );
endinterface

// File: rtl/key_step_gen.sv
// key_step_gen: INC/DEC edge detect with hold counter and TICK-paced auto-repeat
module key_step_gen #(
    parameter int REPEAT_DLY = 4,
    parameter int TW         = 8
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_tick,
    input  logic i_inc,
    input  logic i_dec,
    output logic o_step_up,
    output logic o_step_dn
);
    logic          r_inc_q, r_dec_q;
    logic [TW-1:0] r_hold;
    logic          w_one, w_rise, w_rpt;

    assign w_one     = i_inc ^ i_dec;
    assign w_rise    = (i_inc & ~r_inc_q) | (i_dec & ~r_dec_q);
    assign w_rpt     = i_tick & (r_hold == TW'(REPEAT_DLY));
    assign o_step_up = w_one & i_inc & (w_rise | w_rpt);
    assign o_step_dn = w_one & i_dec & (w_rise | w_rpt);

    // Hold counter restarts on a fresh single-key press and parks at REPEAT_DLY
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_inc_q <= 1'b0;
            r_dec_q <= 1'b0;
            r_hold  <= '0;
        end else begin
            r_inc_q <= i_inc;
            r_dec_q <= i_dec;
            r_hold  <= (!w_one || w_rise) ? '0 :
                       (i_tick && r_hold != TW'(REPEAT_DLY)) ? r_hold + 1'b1 : r_hold;
        end
    end
endmodule

// File: rtl/set_ctrl.sv
// set_ctrl: setting-mode sequencer driving LOAD/COMMIT/TARGET, field select and
// H/M/S step strobes for the adjust counters
module set_ctrl
    import set_pkg::*;
#(
    parameter int REPEAT_DLY    = 4,
    parameter int TIMEOUT_TICKS = 80,
    parameter int TW            = 8
) (
    input  logic       CP,
    input  logic       CR,
    set_ctrl_if.slave  bus
);
    state_t        r_state;
    field_t        r_field;
    target_t       r_target;
    logic          r_mode_q, r_sel_q;
    logic          r_setting, r_load, r_commit;
    logic [5:0]    r_strb;
    logic [TW-1:0] r_idle;
    logic          w_up, w_dn, w_mode_rise, w_sel_rise, w_in_set, w_quiet, w_timeout, w_step_ok;

    key_step_gen #(.REPEAT_DLY(REPEAT_DLY), .TW(TW)) u_step (
        .i_clk    (CP),
        .i_rst    (CR),
        .i_tick   (bus.TICK),
        .i_inc    (bus.K_INC),
        .i_dec    (bus.K_DEC),
        .o_step_up(w_up),
        .o_step_dn(w_dn)
    );

    assign w_mode_rise = bus.K_MODE & ~r_mode_q;
    assign w_sel_rise  = bus.K_SEL & ~r_sel_q;
    assign w_in_set    = (r_state == SET_T) || (r_state == SET_A);
    assign w_quiet     = ~(w_mode_rise | w_sel_rise | bus.K_INC | bus.K_DEC);
    assign w_timeout   = w_in_set & w_quiet & bus.TICK & (r_idle == TW'(TIMEOUT_TICKS - 1));
    assign w_step_ok   = w_in_set & ~w_mode_rise & ~w_sel_rise;

    always_ff @(posedge CP) begin
        if (CR) begin
            r_state   <= RUN;
            r_field   <= F_NONE;
            r_target  <= T_TIME;
            r_mode_q  <= 1'b0;
            r_sel_q   <= 1'b0;
            r_setting <= 1'b0;
            r_load    <= 1'b0;
            r_commit  <= 1'b0;
            r_strb    <= '0;
            r_idle    <= '0;
        end else begin
            r_mode_q <= bus.K_MODE;
            r_sel_q  <= bus.K_SEL;
            r_load   <= 1'b0;
            r_commit <= 1'b0;
            r_strb   <= w_step_ok ? step_decode(r_field, w_up, w_dn) : '0;
            r_idle   <= (!w_in_set || !w_quiet) ? '0 :
                        (bus.TICK && r_idle != TW'(TIMEOUT_TICKS)) ? r_idle + 1'b1 : r_idle;
            case (r_state)
                RUN: begin
                    r_target <= T_TIME;
                    if (w_mode_rise) begin
                        r_state   <= SET_T;
                        r_load    <= 1'b1;
                        r_field   <= F_H;
                        r_setting <= 1'b1;
                    end
                end
                XFER: begin
                    r_state  <= SET_A;
                    r_load   <= 1'b1;
                    r_target <= T_ALARM;
                    r_field  <= F_H;
                end
                SET_T, SET_A: begin
                    // Final commit from SET_A drops SETTING in the same cycle
                    if (w_mode_rise) begin
                        r_commit  <= 1'b1;
                        r_state   <= (r_state == SET_T) ? XFER : RUN;
                        r_setting <= (r_state == SET_T);
                        r_field   <= (r_state == SET_T) ? r_field : F_NONE;
                    end else if (w_timeout) begin
                        r_state   <= RUN;
                        r_field   <= F_NONE;
                        r_target  <= T_TIME;
                        r_setting <= 1'b0;
                    end else if (w_sel_rise) begin
                        r_field <= (r_field == F_S) ? F_H : field_t'(r_field + 2'd1);
                    end
                end
            endcase
        end
    end

    assign bus.SETTING = r_setting;
    assign bus.TARGET  = r_target;
    assign bus.LOAD    = r_load;
    assign bus.COMMIT  = r_commit;
    assign bus.FIELD   = r_field;
    assign {bus.H_UP, bus.H_DOWN, bus.M_UP, bus.M_DOWN, bus.S_UP, bus.S_DOWN} = r_strb;
endmodule
